bcd_display_mux: RTL and testbench

- Downstream display stage of the calculator datapath.
- Consumes the 4-digit packed BCD word from the binary-to-BCD converter and time-multiplexes it onto a 4-digit common-anode 7-segment display.
- Provides leading-zero blanking, an invalid-digit indication, per-digit decimal points, and tear-free snapshotting of the displayed value once per scan.

---
 rtl/bcd_display_mux_if.sv | 35 +++
 rtl/bcd_display_mux.sv | 156 +++++++++++++++
 tb/tb_bcd_display_mux.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_display_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_mux_if
// Description : Bundle between the BCD source and the 7-segment scan block.
//               master drives the value and controls and reads the display
//               lines; slave is the scan block.
//   num_BCD     [15:0] packed BCD, [3:0] units .. [15:12] thousands
//   enable             1 = scan, 0 = dark
//   blank_ceros        1 = blank leading zero digits
//   puntos      [3:0]  decimal point request per digit, active high
//   anodos      [3:0]  digit enables, active low
//   segmentos   [6:0]  {g,f,e,d,c,b,a}, active low
//   dp                 decimal point, active low
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_display_mux_if;
    logic [15:0] num_BCD;
    logic        enable;
    logic        blank_ceros;
    logic [3:0]  puntos;
    logic [3:0]  anodos;
    logic [6:0]  segmentos;
    logic        dp;

    modport master (
        output num_BCD, enable, blank_ceros, puntos,
        input  anodos, segmentos, dp
    );

    modport slave (
        input  num_BCD, enable, blank_ceros, puntos,
        output anodos, segmentos, dp
    );
endinterface
`default_nettype wire

// File: rtl/bcd_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_mux
// Description : Time-multiplexes a 4-digit packed BCD word onto a 4-digit
//               common-anode 7-segment display. Leading-zero blanking, dash
//               for invalid nibbles, live per-digit decimal points, and a
//               snapshot of the value taken once per scan so digits never
//               tear.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   disp   bcd_display_mux_if.slave (value, controls, display lines)
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_mux #(
    parameter int REFRESH_DIV = 50000
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    bcd_display_mux_if.slave   disp
);

    localparam int c_CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(REFRESH_DIV - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    localparam logic [3:0] c_AN_OFF  = 4'hF;
    localparam logic [6:0] c_SEG_OFF = 7'h7F;

    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_div_cnt;
    logic [1:0]         r_idx;
    logic [15:0]        r_latch;
    logic [3:0]         r_anodos;
    logic [6:0]         r_segmentos;
    logic               r_dp;

    logic [0:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_div_nxt;
    logic [1:0]         w_idx_nxt;
    logic [15:0]        w_latch_nxt;
    logic [3:0]         w_anodos_nxt;
    logic [6:0]         w_segmentos_nxt;
    logic               w_dp_nxt;
    logic [3:0]         w_nib;
    logic [3:0]         w_zero_from;
    logic               w_blank;

    // Active-low segment pattern; anything above 9 shows a dash.
    function automatic logic [6:0] f_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_div_cnt   <= '0;
            r_idx       <= 2'd0;
            r_latch     <= 16'h0000;
            r_anodos    <= c_AN_OFF;
            r_segmentos <= c_SEG_OFF;
            r_dp        <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_div_cnt   <= w_div_nxt;
            r_idx       <= w_idx_nxt;
            r_latch     <= w_latch_nxt;
            r_anodos    <= w_anodos_nxt;
            r_segmentos <= w_segmentos_nxt;
            r_dp        <= w_dp_nxt;
        end
    end

    // Next-state: scan timing and snapshot
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div_cnt;
        w_idx_nxt   = r_idx;
        w_latch_nxt = r_latch;
        case (r_state)
            c_IDLE: begin
                w_div_nxt = '0;
                w_idx_nxt = 2'd0;
                if (disp.enable) begin
                    w_state_nxt = c_RUN;
                    w_latch_nxt = disp.num_BCD;
                end
            end
            c_RUN: begin
                if (!disp.enable) begin
                    w_state_nxt = c_IDLE;
                    w_div_nxt   = '0;
                    w_idx_nxt   = 2'd0;
                end else if (r_div_cnt == c_DIV_LAST) begin
                    w_div_nxt = '0;
                    w_idx_nxt = r_idx + 2'd1;
                    // Fresh snapshot only when the scan wraps to digit 0
                    if (r_idx == 2'd3) begin
                        w_latch_nxt = disp.num_BCD;
                    end
                end else begin
                    w_div_nxt = r_div_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_div_nxt   = '0;
                w_idx_nxt   = 2'd0;
            end
        endcase
    end

    // Outputs: decoded from the next digit/snapshot so a slot change shows on
    // the same edge. Recomputed every edge so dp and blanking track live.
    always_comb begin
        w_nib = w_latch_nxt[{w_idx_nxt, 2'b00} +: 4];

        // w_zero_from[i]: nibbles i..3 all zero; digit 0 is never blanked
        w_zero_from[3] = (w_latch_nxt[15:12] == 4'h0);
        w_zero_from[2] = w_zero_from[3] && (w_latch_nxt[11:8] == 4'h0);
        w_zero_from[1] = w_zero_from[2] && (w_latch_nxt[7:4] == 4'h0);
        w_zero_from[0] = 1'b0;
        w_blank        = disp.blank_ceros && w_zero_from[w_idx_nxt];

        w_anodos_nxt    = c_AN_OFF;
        w_segmentos_nxt = c_SEG_OFF;
        w_dp_nxt        = 1'b1;
        if ((w_state_nxt == c_RUN) && !w_blank) begin
            w_anodos_nxt    = ~(4'b0001 << w_idx_nxt);
            w_segmentos_nxt = f_seg(w_nib);
            w_dp_nxt        = ~disp.puntos[w_idx_nxt];
        end
    end

    assign disp.anodos    = r_anodos;
    assign disp.segmentos = r_segmentos;
    assign disp.dp        = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_display_mux
// Description : Directed self-checking bench for bcd_display_mux with
//               REFRESH_DIV=4. Outputs are sampled 1 time unit after each
//               rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_display_mux;

    localparam int c_DIV = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    bcd_display_mux_if disp_if ();

    bcd_display_mux #(.REFRESH_DIV(c_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .disp  (disp_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leave RUN, then enable; returns just after the enabling edge.
    task automatic restart();
        disp_if.enable = 1'b0;
        tick();
        disp_if.enable = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        disp_if.enable = 1'b0;
        disp_if.num_BCD = 16'h1234;
        disp_if.blank_ceros = 1'b0;
        disp_if.puntos = 4'h0;
        tick();
        tick();
        total++; if (disp_if.anodos !== 4'hF) begin bad++; $display("FAIL rst_anodos got=%h exp=F", disp_if.anodos); end
        total++; if (disp_if.segmentos !== 7'h7F) begin bad++; $display("FAIL rst_seg got=%h exp=7F", disp_if.segmentos); end
        total++; if (disp_if.dp !== 1'b1) begin bad++; $display("FAIL rst_dp got=%b exp=1", disp_if.dp); end
        rst_n = 1'b1;
        disp_if.enable = 1'b1;
        tick();
        total++; if (disp_if.anodos !== 4'hE) begin bad++; $display("FAIL rst_first_en got=%h exp=E", disp_if.anodos); end
        for (int i = 0; i < 5; i++) tick();
        // Mid-scan asynchronous reset, checked before the next edge
        #2 rst_n = 1'b0;
        #1;
        total++; if (disp_if.anodos !== 4'hF) begin bad++; $display("FAIL async_rst_anodos got=%h exp=F", disp_if.anodos); end
        total++; if (disp_if.segmentos !== 7'h7F) begin bad++; $display("FAIL async_rst_seg got=%h exp=7F", disp_if.segmentos); end
        total++; if (disp_if.dp !== 1'b1) begin bad++; $display("FAIL async_rst_dp got=%b exp=1", disp_if.dp); end
        disp_if.enable = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (disp_if.anodos !== 4'hF || disp_if.segmentos !== 7'h7F) begin
                bad++; $display("FAIL rst_idle_dark got=%h/%h exp=F/7F", disp_if.anodos, disp_if.segmentos);
            end
        end
    endtask

    task automatic test_scan();
        logic [3:0] ea [4];
        logic [6:0] es [4];
        int d;
        ea = '{4'hE, 4'hD, 4'hB, 4'h7};
        es = '{7'h19, 7'h30, 7'h24, 7'h79};
        disp_if.num_BCD = 16'h1234;
        disp_if.blank_ceros = 1'b0;
        disp_if.puntos = 4'h0;
        restart();
        for (int k = 0; k < 8 * c_DIV; k++) begin
            d = (k / c_DIV) % 4;
            total++; if (disp_if.anodos !== ea[d] || disp_if.segmentos !== es[d] || disp_if.dp !== 1'b1) begin
                bad++; $display("FAIL scan k=%0d got=%h/%h/%b exp=%h/%h/1", k, disp_if.anodos, disp_if.segmentos, disp_if.dp, ea[d], es[d]);
            end
            tick();
        end
    endtask

    task automatic test_blanking();
        logic [3:0]  ea [3][4];
        logic [6:0]  es [3][4];
        logic [15:0] nums [3];
        logic        bl [3];
        int d;
        nums = '{16'h0045, 16'h0000, 16'h0045};
        bl   = '{1'b1, 1'b1, 1'b0};
        ea = '{'{4'hE, 4'hD, 4'hF, 4'hF}, '{4'hE, 4'hF, 4'hF, 4'hF}, '{4'hE, 4'hD, 4'hB, 4'h7}};
        es = '{'{7'h12, 7'h19, 7'h7F, 7'h7F}, '{7'h40, 7'h7F, 7'h7F, 7'h7F}, '{7'h12, 7'h19, 7'h40, 7'h40}};
        disp_if.puntos = 4'hF;
        for (int v = 0; v < 3; v++) begin
            disp_if.num_BCD = nums[v];
            disp_if.blank_ceros = bl[v];
            restart();
            for (int k = 0; k < 4 * c_DIV; k++) begin
                d = k / c_DIV;
                total++; if (disp_if.anodos !== ea[v][d] || disp_if.segmentos !== es[v][d] || disp_if.dp !== (ea[v][d] == 4'hF)) begin
                    bad++; $display("FAIL blank v=%0d k=%0d got=%h/%h/%b exp=%h/%h", v, k, disp_if.anodos, disp_if.segmentos, disp_if.dp, ea[v][d], es[v][d]);
                end
                tick();
            end
        end
        disp_if.puntos = 4'h0;
    endtask

    task automatic test_invalid_dp();
        logic [3:0] ea [2][4];
        logic [6:0] es [2][4];
        logic       ed [2][4];
        logic [15:0] nums [2];
        logic        bl [2];
        int d;
        nums = '{16'h12A4, 16'h0A00};
        bl   = '{1'b0, 1'b1};
        ea = '{'{4'hE, 4'hD, 4'hB, 4'h7}, '{4'hE, 4'hD, 4'hB, 4'hF}};
        es = '{'{7'h19, 7'h3F, 7'h24, 7'h79}, '{7'h40, 7'h40, 7'h3F, 7'h7F}};
        ed = '{'{1'b1, 1'b1, 1'b0, 1'b1}, '{1'b1, 1'b1, 1'b0, 1'b1}};
        disp_if.puntos = 4'b0100;
        for (int v = 0; v < 2; v++) begin
            disp_if.num_BCD = nums[v];
            disp_if.blank_ceros = bl[v];
            restart();
            for (int k = 0; k < 4 * c_DIV; k++) begin
                d = k / c_DIV;
                total++; if (disp_if.anodos !== ea[v][d] || disp_if.segmentos !== es[v][d] || disp_if.dp !== ed[v][d]) begin
                    bad++; $display("FAIL invalid_dp v=%0d k=%0d got=%h/%h/%b exp=%h/%h/%b", v, k, disp_if.anodos, disp_if.segmentos, disp_if.dp, ea[v][d], es[v][d], ed[v][d]);
                end
                tick();
            end
        end
        disp_if.puntos = 4'h0;
        disp_if.blank_ceros = 1'b0;
    endtask

    task automatic test_tearing();
        logic [3:0] ea [4];
        logic [6:0] exp_seg;
        ea = '{4'hE, 4'hD, 4'hB, 4'h7};
        disp_if.num_BCD = 16'h1111;
        restart();
        for (int k = 0; k < 6 * c_DIV; k++) begin
            exp_seg = (k >= 4 * c_DIV) ? 7'h10 : 7'h79;
            total++; if (disp_if.anodos !== ea[(k / c_DIV) % 4] || disp_if.segmentos !== exp_seg) begin
                bad++; $display("FAIL tearing k=%0d got=%h/%h exp=%h/%h", k, disp_if.anodos, disp_if.segmentos, ea[(k / c_DIV) % 4], exp_seg);
            end
            if (k == c_DIV + 1) disp_if.num_BCD = 16'h9999;
            tick();
        end
    endtask

    task automatic test_reenable();
        disp_if.num_BCD = 16'h1234;
        restart();
        for (int k = 0; k < 2 * c_DIV + 1; k++) tick();
        total++; if (disp_if.anodos !== 4'hB || disp_if.segmentos !== 7'h24) begin
            bad++; $display("FAIL reen_slot2 got=%h/%h exp=B/24", disp_if.anodos, disp_if.segmentos);
        end
        disp_if.enable = 1'b0;
        disp_if.num_BCD = 16'h5678;
        tick();
        total++; if (disp_if.anodos !== 4'hF || disp_if.segmentos !== 7'h7F || disp_if.dp !== 1'b1) begin
            bad++; $display("FAIL reen_dark got=%h/%h/%b exp=F/7F/1", disp_if.anodos, disp_if.segmentos, disp_if.dp);
        end
        tick();
        total++; if (disp_if.anodos !== 4'hF) begin bad++; $display("FAIL reen_dark2 got=%h exp=F", disp_if.anodos); end
        disp_if.enable = 1'b1;
        tick();
        for (int k = 0; k < c_DIV + 2; k++) begin
            total++; if (k < c_DIV) begin
                if (disp_if.anodos !== 4'hE || disp_if.segmentos !== 7'h00) begin
                    bad++; $display("FAIL reen_d0 k=%0d got=%h/%h exp=E/00", k, disp_if.anodos, disp_if.segmentos);
                end
            end else if (disp_if.anodos !== 4'hD || disp_if.segmentos !== 7'h78) begin
                bad++; $display("FAIL reen_d1 k=%0d got=%h/%h exp=D/78", k, disp_if.anodos, disp_if.segmentos);
            end
            tick();
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_scan();
        test_blanking();
        test_invalid_dp();
        test_tearing();
        test_reenable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
